// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

    // PC value loaded on reset and held through the boot cycle.
    localparam logic [15:0] FU_RESET_PC  = 16'h0000;
    // Instructions are 16 bits wide and byte addressed, so the PC steps by 2.
    localparam int unsigned FU_PC_STEP   = 2;
    // Payload value of an empty pipeline register.
    localparam logic [15:0] FU_NOP_INSTR = 16'h0000;

    // BOOT covers reset and the first cycle after release; RUN is normal fetch.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/control side.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    // memory port
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instruction;
    // control-flow and hazard inputs
    logic                   stall;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    // IF/ID handshake and payload
    logic                   ifid_valid;
    logic                   ifid_ready;
    logic [INSTR_WIDTH-1:0] ifid_instr;
    logic [PC_WIDTH-1:0]    ifid_pc;
    logic [PC_WIDTH-1:0]    ifid_pc_next;
    // status
    logic                   misalign;
    logic [15:0]            fetch_count;

    modport master (
        output pc,
        input  instruction,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output ifid_valid,
        input  ifid_ready,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_next,
        output misalign,
        output fetch_count
    );

    modport slave (
        input  pc,
        output instruction,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  ifid_valid,
        output ifid_ready,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_next,
        input  misalign,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register (ifid_reg): instruction payload plus valid bit.
// Flush clears the valid bit only; load captures a new entry; otherwise the
// entry holds. Generic enough to serve as the ID/EX register as well.
module fetch_unit_ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter int W_INSTR = 16,
    parameter int W_PC    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [W_INSTR-1:0] instr_i,
    input  logic [W_PC-1:0]    pc_i,
    input  logic [W_PC-1:0]    pc_next_i,
    output logic               valid_o,
    output logic [W_INSTR-1:0] instr_o,
    output logic [W_PC-1:0]    pc_o,
    output logic [W_PC-1:0]    pc_next_o
);

    logic               valid_q;
    logic [W_INSTR-1:0] instr_q;
    logic [W_PC-1:0]    pc_q;
    logic [W_PC-1:0]    pc_next_q;

    // Flush wins over load; payload only changes on a load so it stays
    // stable while the consumer applies backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= W_INSTR'(FU_NOP_INSTR);
            pc_q      <= '0;
            pc_next_q <= '0;
        end else if (flush_i) begin
            valid_q   <= 1'b0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            pc_next_q <= pc_next_i;
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, boot/run FSM, redirect/stall/backpressure
// priority and accepted-instruction counter. Memory read data arrives
// combinationally for the current PC and is captured into the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(FU_RESET_PC)
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
);

    fetch_state_e        state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                misalign_q;
    logic [15:0]         fetch_count_q;

    logic                run_d;
    logic                slot_free_d;
    logic                load_d;
    logic                flush_d;
    logic [PC_WIDTH-1:0] pc_inc_d;
    logic [PC_WIDTH-1:0] redirect_tgt_d;

    // Decode the per-edge priority: redirect > stall > free slot > hold.
    always_comb begin
        run_d          = (state_q == RUN);
        slot_free_d    = !bus.ifid_valid || bus.ifid_ready;
        pc_inc_d       = pc_q + PC_WIDTH'(FU_PC_STEP);
        redirect_tgt_d = {bus.redirect_pc[PC_WIDTH-1:1], 1'b0};
        // A stall while decode consumes the entry leaves a bubble behind it.
        flush_d        = run_d && (bus.redirect_valid ||
                                   (bus.stall && bus.ifid_valid && bus.ifid_ready));
        load_d         = run_d && !bus.redirect_valid && !bus.stall && slot_free_d;
    end

    // FSM with PC, misalign pulse and fetch counter as registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_q       <= RESET_PC;
                    misalign_q <= 1'b0;
                end
                RUN: begin
                    misalign_q <= 1'b0;
                    if (bus.redirect_valid) begin
                        // Target is forced even; bit 0 only raises the flag.
                        pc_q       <= redirect_tgt_d;
                        misalign_q <= bus.redirect_pc[0];
                    end else if (load_d) begin
                        pc_q          <= pc_inc_d;
                        fetch_count_q <= fetch_count_q + 16'd1;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    fetch_unit_ifid_reg #(
        .W_INSTR (INSTR_WIDTH),
        .W_PC    (PC_WIDTH)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_d),
        .flush_i   (flush_d),
        .instr_i   (bus.instruction),
        .pc_i      (pc_q),
        .pc_next_i (pc_inc_d),
        .valid_o   (bus.ifid_valid),
        .instr_o   (bus.ifid_instr),
        .pc_o      (bus.ifid_pc),
        .pc_next_o (bus.ifid_pc_next)
    );

    assign bus.pc          = pc_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a 16-word aliasing memory.
module tb_fetch_unit;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word k holds A0A0+k, indexed by pc[4:1].
    logic [15:0] mem [0:15];
    assign bus.instruction = mem[bus.pc[4:1]];

    typedef struct {
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic        ready;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eipc;
        logic [15:0] eins;
        logic [15:0] einx;
        logic        emis;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vec [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] epc,
                           input logic [15:0] eipc, input logic [15:0] eins,
                           input logic [15:0] einx, input logic emis, input logic [15:0] ecnt);
        chk({tag, ".ifid_valid"},   16'(bus.ifid_valid), 16'(ev));
        chk({tag, ".pc"},           bus.pc,              epc);
        chk({tag, ".ifid_pc"},      bus.ifid_pc,         eipc);
        chk({tag, ".ifid_instr"},   bus.ifid_instr,      eins);
        chk({tag, ".ifid_pc_next"}, bus.ifid_pc_next,    einx);
        chk({tag, ".misalign"},     16'(bus.misalign),   16'(emis));
        chk({tag, ".fetch_count"},  bus.fetch_count,     ecnt);
    endtask

    // Apply rows lo..hi, one clock edge each, checking 1 time unit after the edge.
    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.stall          = vec[i].stall;
            bus.redirect_valid = vec[i].rv;
            bus.redirect_pc    = vec[i].rpc;
            bus.ifid_ready     = vec[i].ready;
            @(posedge clk);
            #1;
            $display("vec %0d: stall=%b rv=%b rpc=%h rdy=%b -> v=%b pc=%h ipc=%h ins=%h inx=%h mis=%b cnt=%0d",
                     i, vec[i].stall, vec[i].rv, vec[i].rpc, vec[i].ready, bus.ifid_valid,
                     bus.pc, bus.ifid_pc, bus.ifid_instr, bus.ifid_pc_next, bus.misalign,
                     bus.fetch_count);
            chk_all($sformatf("vec%0d", i), vec[i].ev, vec[i].epc, vec[i].eipc,
                    vec[i].eins, vec[i].einx, vec[i].emis, vec[i].ecnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 16'hA0A0 + 16'(k);

        //                stall rv  rpc       rdy  v    pc        ipc       ins       inx       mis  cnt
        // Phase 1: boot and fetch A..D
        vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0};
        vec[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'hA0A0, 16'h0002, 1'b0, 16'd1};
        vec[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd2};
        vec[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 16'h0004, 16'hA0A2, 16'h0006, 1'b0, 16'd3};
        vec[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h0006, 16'hA0A3, 16'h0008, 1'b0, 16'd4};
        // Phase 2 (after mid-stream reset): boot, backpressure on B
        vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0};
        vec[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'hA0A0, 16'h0002, 1'b0, 16'd1};
        vec[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd2};
        vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd2};
        vec[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd2};
        vec[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd2};
        vec[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 16'h0004, 16'hA0A2, 16'h0006, 1'b0, 16'd3};
        // redirect to 0010, then misaligned redirect to 0011
        vec[12] = '{1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0004, 16'hA0A2, 16'h0006, 1'b0, 16'd3};
        vec[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd4};
        vec[14] = '{1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'hA0A8, 16'h0012, 1'b1, 16'd4};
        vec[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd5};
        // stall two cycles with ready: bubble then hold; stall+redirect; stall holds target
        vec[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd5};
        vec[17] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0012, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd5};
        vec[18] = '{1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0020, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd5};
        vec[19] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0010, 16'hA0A8, 16'h0012, 1'b0, 16'd5};
        vec[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 16'h0020, 16'hA0A0, 16'h0022, 1'b0, 16'd6};
        // wrap around 16'hFFFE
        vec[21] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'hFFFE, 16'h0020, 16'hA0A0, 16'h0022, 1'b0, 16'd6};
        vec[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFE, 16'hA0AF, 16'h0000, 1'b0, 16'd7};
        vec[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'hA0A0, 16'h0002, 1'b0, 16'd8};
        // stall while decode is not ready: entry held
        vec[24] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'hA0A0, 16'h0002, 1'b0, 16'd8};
        vec[25] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd9};
        // redirect overrides backpressure and flushes the held entry
        vec[26] = '{1'b0, 1'b1, 16'h0006, 1'b0, 1'b0, 16'h0006, 16'h0002, 16'hA0A1, 16'h0004, 1'b0, 16'd9};
        vec[27] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h0006, 16'hA0A3, 16'h0008, 1'b0, 16'd10};

        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.ifid_ready     = 1'b1;
        rst_n              = 1'b0;

        // Reset state, including across clock edges while held in reset.
        #2;
        chk_all("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset_held", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
        rst_n = 1'b1;

        apply(0, 4);

        // Asynchronous reset between edges: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: v=%b pc=%h ipc=%h ins=%h cnt=%0d",
                 bus.ifid_valid, bus.pc, bus.ifid_pc, bus.ifid_instr, bus.fetch_count);
        chk_all("async_reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply(5, NVEC - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit RISC core. It owns the program counter, drives `pc` into `Instruction_Memory`, and captures the combinational `instruction` it returns into an IF/ID pipeline register. That register feeds decode over a valid/ready handshake. It also handles sequential fetch, control-flow redirects (flush), and hazard stalls.

## Interface
Parameters:
- `PC_WIDTH`, 16, program-counter width.
- `INSTR_WIDTH`, 16, instruction width; equals the memory column width `` `col ``.
- `RESET_PC`, 16'h0000, PC value after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  PC_WIDTH  fetch address to `Instruction_Memory`.
- `instruction`  in  INSTR_WIDTH  combinational read data for `pc`.
- `stall`  in  1  decode hazard; freeze fetch.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  PC_WIDTH  redirect target.
- `ifid_valid`  out  1  IF/ID entry holds a live instruction.
- `ifid_ready`  in  1  decode accepts the IF/ID entry this cycle.
- `ifid_instr`  out  INSTR_WIDTH  captured instruction.
- `ifid_pc`  out  PC_WIDTH  address of `ifid_instr`.
- `ifid_pc_next`  out  PC_WIDTH  `ifid_pc + 2`, the link value for jumps.
- `misalign`  out  1  one-cycle pulse: the redirect target had bit 0 set.
- `fetch_count`  out  16  count of instructions accepted into IF/ID.

## Operation
- FSM has two states: BOOT and RUN.
  - BOOT is the state during reset and for the first cycle after deassertion. No capture happens. The PC holds `RESET_PC`. The FSM goes to RUN on the next edge.
  - RUN is normal fetch. It leaves RUN only on reset.
- In RUN, the IF/ID slot is free when `!ifid_valid || ifid_ready`.
- Per-edge priority in RUN:
  1. `redirect_valid`:
     - `pc <= {redirect_pc[15:1],1'b0}`.
     - `ifid_valid <= 0` (flush).
     - `misalign <= redirect_pc[0]`.
     - Overrides `stall` and `ifid_ready`.
  2. `stall`:
     - PC holds.
     - If `ifid_valid && ifid_ready`, then `ifid_valid <= 0` (bubble). Otherwise the IF/ID register holds.
  3. Slot free:
     - `ifid_instr <= instruction`, `ifid_pc <= pc`, `ifid_pc_next <= pc+2`.
     - `ifid_valid <= 1`.
     - `pc <= pc+2`.
     - `fetch_count++`.
  4. Otherwise (valid, not ready): everything holds.
- PC arithmetic is modulo 2^16: 16'hFFFE+2 = 16'h0000. The PC always increments by 2.
- The memory indexes `pc[4:1]`, so the image aliases every 32 bytes. This block does not detect aliasing.
- `fetch_count` wraps at 16'hFFFF→0. Flushed entries are not subtracted.
- IF/ID contents change only on capture. `ifid_instr`, `ifid_pc` and `ifid_pc_next` are stable while `ifid_valid && !ifid_ready`.

## Timing
- Reset values (asynchronous):
  - `pc = RESET_PC`.
  - `ifid_valid = 0`.
  - `ifid_instr = 0`, `ifid_pc = 0`, `ifid_pc_next = 0`.
  - `misalign = 0`.
  - `fetch_count = 0`.
  - State = BOOT.
- `pc` is a register output. The memory read is combinational within the same cycle, and capture happens at the following edge. Fetch-to-IF/ID latency is 1 cycle.
- First instruction: `rst_n` rises before edge E0. E0 is BOOT→RUN. At E1, `ifid_valid=1` with the instruction at `RESET_PC`.
- Redirect sampled at edge N:
  - After N: `ifid_valid=0`, `pc=target`.
  - After N+1: the target instruction is valid, provided the slot is free and there is no stall.
  - Penalty is one bubble.
- Redirect and stall together: the redirect wins and the PC loads the target. The stall then holds the PC at the target.
- Reset mid-operation clears all state immediately. Any in-flight IF/ID entry is discarded.
- Throughput is one instruction per cycle while `ifid_ready=1`, `stall=0` and there is no redirect.

## Structure
- Shared constants go in `Parameter.v`, alongside `` `col `` and `` `row_i ``:
  - `` `RESET_PC ``
  - `` `PC_STEP `` (2)
  - `` `NOP_INSTR `` (16'h0000)
- Sub-module `ifid_reg` holds the IF/ID payload plus the valid bit. It has load, flush and hold controls and is reused for the later ID/EX stage.
- `fetch_unit` holds the FSM, the PC register, the priority logic and `fetch_count`.
- `fetch_unit` instantiates `ifid_reg` and connects to `Instruction_Memory` at the top level.

## Test plan
- Reset release with memory words 0..3 = A,B,C,D and `ifid_ready=1`:
  - `ifid_valid` rises one edge after BOOT.
  - `ifid_pc` runs 0,2,4,6 with `ifid_instr` A,B,C,D.
  - `fetch_count` = 4.
- Backpressure: `ifid_ready=0` for 3 cycles while holding B at `ifid_pc=2`:
  - The IF/ID register and `pc=4` stay frozen.
  - On release, C is at `ifid_pc=4` on the next edge.
- Redirect to 16'h0010:
  - Next cycle: `ifid_valid=0`, `pc=16'h0010`.
  - Following cycle: `ifid_pc=16'h0010`, `ifid_pc_next=16'h0012`.
  - A redirect to 16'h0011 gives `pc=16'h0010` with a one-cycle `misalign`.
- `stall` held 2 cycles with `ifid_ready=1`:
  - First edge: bubble, `ifid_valid=0`.
  - PC unchanged.
  - Stall plus redirect in the same cycle: PC takes the target.
- Wrap: redirect to 16'hFFFE, then free-run. `ifid_pc` = FFFE, then 0000, and `ifid_pc_next` of the FFFE entry = 0000.
- Assert `rst_n=0` mid-stream between edges: all outputs go to reset values immediately. After release, fetch restarts at `RESET_PC` with `fetch_count=0`.
